multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Sequencing control unit that drives the RV32I datapath control inputs.
- Moves the design from one instruction per cycle to a multicycle flow: fetch, decode, execute, memory, writeback.
- Decodes opcode/funct fields of the latched instruction and the ALU zero flag into per-cycle enables and mux selects (memory write, register-file write, ALU op, immediate format).
- Also provides a retired-instruction counter and a sticky illegal-instruction trap.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  7  instr[6:0] from instruction register
funct3  input  3  instr[14:12]
funct7_5  input  1  instr[30]
zero  input  1  ALU result-equals-zero flag
pc_write  output  1  PC register load enable
adr_src  output  1  memory address select: 0=PC, 1=ALU result register
mem_write  output  1  data memory write enable
ir_write  output  1  instruction register load enable
reg_write  output  1  register file write enable (port 3)
result_src  output  2  result mux select: 00=ALU out reg, 01=read data, 10=ALU result
alu_src_a  output  2  ALU A select: 00=PC, 01=old PC, 10=rs1 data
alu_src_b  output  2  ALU B select: 00=rs2 data, 01=imm_ext, 10=constant 4
alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  2  extend format: 00 I, 01 S, 10 B, 11 J
trap  output  1  sticky illegal-instruction flag
retired_cnt  output  CNT_W  count of completed instructions

Behaviour:
- State register updates on clk rising edge. Outputs are combinational from state, except pc_write, which also depends on zero.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> TRAP
  - DECODE to TRAP also when the opcode is 0110011 or 0010011 and funct3 is not in {000, 010, 110, 111}.
  - MEMADR -> MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECR, EXECI, JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - TRAP holds until reset.
- Per-state outputs (anything not listed is 0; alu_op is internal):
  - FETCH: ir_write=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10, pc_update=1.
  - DECODE: a=01, b=01, alu_op=00 (branch target precompute).
  - MEMADR: a=10, b=01, alu_op=00.
  - MEMREAD: adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECR: a=10, b=00, alu_op=10.
  - EXECI: a=10, b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: a=10, b=00, alu_op=01, branch=1.
  - JAL: a=01, b=10, alu_op=00, pc_update=1.
  - TRAP: all enables 0.
- pc_write = pc_update | (branch & zero).
- ALU decode from alu_op:
  - 00 -> 000.
  - 01 -> 001.
  - 10, by funct3:
    - 000 -> 001 if opcode[5] & funct7_5, else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
- imm_src from opcode, independent of state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- Latency in cycles including FETCH: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4.
- retired_cnt increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W with no saturation.
- trap sets on entry to TRAP; retired_cnt does not advance in TRAP.
- Reset (rst=0):
  - Asynchronous: state=FETCH, retired_cnt=0, trap=0.
  - While rst=0, pc_write, ir_write, mem_write and reg_write are forced to 0 regardless of state.
  - Reset asserted mid-instruction abandons it with no partial writes after assertion; the first post-release edge executes FETCH.

Test Plan:
- lw (opcode 0000011) after reset: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. reg_write=1 and result_src=01 only in the 5th cycle; retired_cnt 0 -> 1.
- sw (0100011): mem_write=1, adr_src=1 only in the 4th cycle. imm_src=01 throughout. reg_write never 1.
- R-type sub (0110011, funct3=000, funct7_5=1): alu_ctrl=001 in EXECR. R-type slt (funct3=010): alu_ctrl=101. I-type addi with funct7_5=1: alu_ctrl=000.
- beq (1100011): zero=1 in the BEQ cycle -> pc_write=1, then FETCH. With zero=0 -> pc_write=0. Both return to FETCH after 3 cycles, and retired_cnt increments.
- Illegal opcode 1111111, or R-type with funct3=001: enter TRAP, trap=1, all enables 0 for 20 cycles, retired_cnt frozen. rst=0 then clears trap and returns to FETCH.
- Reset pulse during MEMWRITE: mem_write drops to 0 asynchronously while rst=0, and retired_cnt=0. After release, state is FETCH with ir_write=1.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// The controller (master) reads instruction fields and the ALU zero flag
// and drives every datapath enable and mux select. The datapath (slave)
// owns the instruction register and ALU.
//
// Handshake: there is no valid/ready pair. The instruction fields are
// qualified by the controller's own state: they are sampled by the
// next-state logic only in DECODE and MEMADR, after ir_write in FETCH has
// loaded the instruction register. The datapath must hold them stable
// from the end of FETCH until the instruction returns to FETCH.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  // Instruction fields and status from the datapath
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             zero;

  // Enables and selects toward the datapath
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_ctrl;
  logic [1:0]       imm_src;

  // Status
  logic             trap;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    input  opcode, funct3, funct7_5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
    output result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src,
    output trap, retired_cnt
  );

  modport slave (
    output opcode, funct3, funct7_5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, alu_ctrl, imm_src,
    input  trap, retired_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for an RV32I datapath: fetch, decode, execute,
// memory, writeback. Supports lw, sw, R-type and I-type ALU ops
// (add/sub, slt, or, and), beq and jal. Anything else lands in a sticky
// TRAP state that only reset leaves. Also counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,       // asynchronous, active low
  multicycle_ctrl_if.master   bus,
  output logic [3:0]          state_dbg  // current FSM state encoding
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t           state_q;
  state_t           state_d;
  logic             f3_alu_ok;
  logic             pc_update;
  logic             branch;
  logic [1:0]       alu_op;
  logic             ir_write_raw;
  logic             mem_write_raw;
  logic             reg_write_raw;
  logic             trap_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  assign state_dbg = state_q;

  // Only the ALU funct3 encodings this datapath implements are legal
  always_comb begin
    f3_alu_ok = 1'b0;
    case (bus.funct3)
      3'b000, 3'b010, 3'b110, 3'b111: f3_alu_ok = 1'b1;
      default:                        f3_alu_ok = 1'b0;
    endcase
  end

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = f3_alu_ok ? S_EXECR : S_TRAP;
          OP_ITYPE:          state_d = f3_alu_ok ? S_EXECI : S_TRAP;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; unlisted controls stay at zero
  always_comb begin
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    alu_op         = 2'b00;
    bus.adr_src    = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    case (state_q)
      S_FETCH: begin
        // PC + 4 computed and written back through the ALU result path
        ir_write_raw   = 1'b1;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        pc_update      = 1'b1;
      end
      S_DECODE: begin
        // Branch target precomputed from old PC + immediate
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        bus.adr_src = 1'b1;
      end
      S_MEMWB: begin
        bus.result_src = 2'b01;
        reg_write_raw  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adr_src   = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b00;
        alu_op        = 2'b10;
      end
      S_EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        alu_op        = 2'b10;
      end
      S_ALUWB: begin
        bus.result_src = 2'b00;
        reg_write_raw  = 1'b1;
      end
      S_BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b00;
        alu_op        = 2'b01;
        branch        = 1'b1;
      end
      S_JAL: begin
        // Link value old PC + 4; PC takes the target from DECODE
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_update     = 1'b1;
      end
      default: begin
        // TRAP and unused encodings drive nothing
      end
    endcase
  end

  // ALU function decode; sub only for R-type with funct7[5] set
  always_comb begin
    bus.alu_ctrl = 3'b000;
    case (alu_op)
      2'b01: bus.alu_ctrl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.alu_ctrl = (bus.opcode[5] & bus.funct7_5) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_ctrl = 3'b101;
          3'b110:  bus.alu_ctrl = 3'b011;
          3'b111:  bus.alu_ctrl = 3'b010;
          default: bus.alu_ctrl = 3'b000;
        endcase
      end
      default: bus.alu_ctrl = 3'b000;
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    bus.imm_src = 2'b00;
    case (bus.opcode)
      OP_STORE:  bus.imm_src = 2'b01;
      OP_BRANCH: bus.imm_src = 2'b10;
      OP_JAL:    bus.imm_src = 2'b11;
      default:   bus.imm_src = 2'b00;
    endcase
  end

  // Write enables are gated by reset so nothing is written while it is held
  always_comb begin
    bus.pc_write  = rst & (pc_update | (branch & bus.zero));
    bus.ir_write  = rst & ir_write_raw;
    bus.mem_write = rst & mem_write_raw;
    bus.reg_write = rst & reg_write_raw;
  end

  // The last state of every legal instruction always returns to FETCH
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: retire = 1'b1;
      default:                             retire = 1'b0;
    endcase
  end

  // Sticky trap flag, set on the edge that enters TRAP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     trap_q <= 1'b0;
    else if (state_d == S_TRAP)   trap_q <= 1'b1;
  end

  // Retired-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.trap        = trap_q;
  assign bus.retired_cnt = cnt_q;

endmodule
